bus_trace_uart: RTL and testbench
=================================

BUS_TRACE_UART -- requirements
Module: bus_trace_uart

Interface
REQ-001 Parameter DEPTH, default 16, event FIFO entries; power of two, 4..256.
REQ-002 Parameter WIN_LO, default 16'h2000, inclusive lower bound of the memory capture window.
REQ-003 Parameter WIN_HI, default 16'h4000, exclusive upper bound of the memory capture window.
REQ-004 Parameter DIR_MASK, default 2'b11; bit0 enables read capture, bit1 enables write capture.
REQ-005 Parameter LED_HOLD, default 24'hFFFFFF, activity LED stretch in clk cycles.
REQ-006 clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-007 greset  input  1  asynchronous, active-low reset.
REQ-008 A  input  16  Z80 address bus, asynchronous to clk.
REQ-009 D_IN  input  8  Z80 data bus, from the pad input register.
REQ-010 MREQ_n, RD_n, WR_n  input  1 each  Z80 strobes, active-low, asynchronous.
REQ-011 tx_req  output  1  one-cycle byte-valid pulse to uart_tx.
REQ-012 tx_data  output  8  byte for uart_tx, valid when tx_req=1.
REQ-013 tx_ready  input  1  uart_tx can accept a byte.
REQ-014 overflow  output  1  sticky: at least one event was dropped.
REQ-015 dropped  output  8  count of dropped events, saturating at 8'hFF.
REQ-016 LED1  output  1  activity indicator.

Function
REQ-017 MREQ_n, RD_n and WR_n SHALL each pass through a two-flop synchroniser before use.
REQ-018 An event SHALL be detected on the first cycle where synced MREQ_n=0 and (synced RD_n=0 or synced WR_n=0), having been false the previous cycle.
REQ-019 On detection, A and D_IN SHALL be sampled that same cycle; an event is accepted only if WIN_LO <= A < WIN_HI and its direction is enabled in DIR_MASK.
REQ-020 If both RD_n and WR_n are low at detection, the event SHALL be classed as a write.
REQ-021 An accepted event SHALL be pushed as a 25-bit entry {dir, A, D} into the FIFO, where dir=1 means write.
REQ-022 If the FIFO is full, the event SHALL be dropped: overflow<=1, and dropped increments unless it already equals 8'hFF.
REQ-023 A push and a pop in the same cycle SHALL both take effect; a push on a full FIFO with a same-cycle pop SHALL be accepted.
REQ-024 The formatter FSM SHALL have three states: IDLE, SEND and GAP.
REQ-025 IDLE: if the FIFO is non-empty, pop one entry into the line register, set idx=0, and go to SEND.
REQ-026 SEND: when tx_ready=1, drive tx_data=char[idx] with tx_req=1 for exactly one cycle, then go to GAP.
REQ-027 GAP: lasts one cycle; if idx=10, go to IDLE, otherwise increment idx and go to SEND.
REQ-028 The line SHALL be 11 bytes, in order:
  - 'R' or 'W', then space;
  - 4 uppercase hex digits of A, MSB first, then space;
  - 2 uppercase hex digits of D;
  - 8'h0D, 8'h0A.
REQ-029 Nibble-to-ASCII conversion: 0-9 -> 8'h30-8'h39; A-F -> 8'h41-8'h46.
REQ-030 tx_req SHALL never be asserted while tx_ready=0.
REQ-031 LED1 SHALL be high while a stretch counter is non-zero; each accepted event reloads the counter to LED_HOLD, and it otherwise decrements to 0.
REQ-032 Latency: the first tx_req of a line SHALL occur no earlier than 4 cycles after the raw strobe falls when the FIFO was empty and tx_ready=1.

Reset
REQ-033 While greset=0, the following SHALL hold:
  - tx_req=0, tx_data=0;
  - overflow=0, dropped=0, LED1=0;
  - FIFO empty, FSM in IDLE, idx=0;
  - synchroniser flops=1.
REQ-034 Assertion of greset mid-line SHALL abort the line immediately; after release, no partial line resumes.
REQ-035 For the first 2 cycles after release, no event SHALL be detected.

Configuration
REQ-036 Macro BUS_TRACE_IORQ_EN: when defined, the module SHALL add input IORQ_n (1 bit, active-low, synchronised like the other strobes).
REQ-037 With BUS_TRACE_IORQ_EN, an I/O event is IORQ_n=0 with RD_n or WR_n low and MREQ_n=1, detected on the same edge rule.
  - The window is ignored for I/O events; DIR_MASK still applies.
  - Type character is 'I' for a read and 'O' for a write.
  - Address digits are "00" followed by A[7:0].
  - Entry width becomes 26 bits, adding an io flag.
REQ-038 Without BUS_TRACE_IORQ_EN, no IORQ_n port SHALL exist and only memory events are captured.

Verification
REQ-039 Memory write: A=16'h2ABC, D=8'h5E, MREQ_n/WR_n low for 6 clk, tx_ready=1 -> bytes "W 2ABC 5E" then 0D 0A, 11 tx_req pulses, LED1=1.
REQ-040 Read at A=16'h4000 and a read at A=16'h1FFF -> no tx_req; a read at A=16'h3FFF, D=8'hA0 -> "R 3FFF A0\r\n".
REQ-041 tx_ready held 0, 20 accepted events with DEPTH=16 -> overflow=1, dropped=4; after releasing tx_ready, 16 lines emitted in arrival order.
REQ-042 Assert greset during the 5th byte of a line -> tx_req=0 immediately; after release with an empty bus, no further bytes and overflow=0.
REQ-043 DIR_MASK=2'b10, one read then one write to 16'h2001 -> only the "W 2001 .." line is emitted.
REQ-044 With BUS_TRACE_IORQ_EN: IORQ_n/WR_n low, A=16'hFF80, D=8'h01 -> "O 0080 01\r\n".

Source files
------------

// File: rtl/bus_trace_uart.sv
// rtl/bus_trace_uart.sv - Z80 bus capture into a FIFO, formatted as ASCII trace lines for a UART.
// Optional I/O-cycle capture is compiled in with BUS_TRACE_IORQ_EN.
module bus_trace_uart #(
    parameter int          DEPTH    = 16,
    parameter logic [15:0] WIN_LO   = 16'h2000,
    parameter logic [15:0] WIN_HI   = 16'h4000,
    parameter logic [1:0]  DIR_MASK = 2'b11,
    parameter logic [23:0] LED_HOLD = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        greset,
    input  logic [15:0] A,
    input  logic [7:0]  D_IN,
    input  logic        MREQ_n,
    input  logic        RD_n,
    input  logic        WR_n,
`ifdef BUS_TRACE_IORQ_EN
    input  logic        IORQ_n,
`endif
    output logic        tx_req,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        overflow,
    output logic [7:0]  dropped,
    output logic        LED1
);
    localparam int AW = $clog2(DEPTH);
`ifdef BUS_TRACE_IORQ_EN
    localparam int EW = 26;
`else
    localparam int EW = 25;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

    logic [1:0]    r_mreq_sync, r_rd_sync, r_wr_sync;
    logic          r_prev;
    logic [1:0]    r_arm;
    logic [AW:0]   r_wptr, r_rptr;
    logic [EW-1:0] r_mem [DEPTH];
    logic          r_overflow;
    logic [7:0]    r_dropped;
    logic [23:0]   r_led;
    state_t        r_state;
    logic [3:0]    r_idx;
    logic [EW-1:0] r_line;
    logic [7:0]    r_tx_data;

    logic w_mreq_s, w_rd_s, w_wr_s, w_iorq_s;
    logic w_strobe, w_mem_act, w_io_act, w_act, w_detect;
    logic w_dir, w_dir_ok, w_in_win, w_accept;
    logic w_empty, w_full, w_push, w_pop;
    logic [EW-1:0] w_entry, w_head;

    assign w_mreq_s = r_mreq_sync[1];
    assign w_rd_s   = r_rd_sync[1];
    assign w_wr_s   = r_wr_sync[1];

`ifdef BUS_TRACE_IORQ_EN
    logic [1:0] r_iorq_sync;
    always_ff @(posedge clk or negedge greset) begin
        if (!greset) r_iorq_sync <= 2'b11;
        else         r_iorq_sync <= {r_iorq_sync[0], IORQ_n};
    end
    assign w_iorq_s = r_iorq_sync[1];
    assign w_entry  = {w_io_act, w_dir, A, D_IN};
`else
    assign w_iorq_s = 1'b1;
    assign w_entry  = {w_dir, A, D_IN};
`endif

    assign w_strobe  = ~w_rd_s | ~w_wr_s;
    assign w_mem_act = ~w_mreq_s & w_strobe;
    assign w_io_act  = ~w_iorq_s & w_mreq_s & w_strobe;
    assign w_act     = w_mem_act | w_io_act;
    assign w_detect  = w_act & ~r_prev & (r_arm == 2'd2);
    // WR_n low wins when both strobes are low
    assign w_dir     = ~w_wr_s;
    assign w_dir_ok  = w_dir ? DIR_MASK[1] : DIR_MASK[0];
    assign w_in_win  = (A >= WIN_LO) && (A < WIN_HI);
    assign w_accept  = w_detect & w_dir_ok & (w_io_act | w_in_win);

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    // Entries stay queued while the UART is stalled so a full FIFO holds DEPTH events
    assign w_pop   = (r_state == ST_IDLE) && !w_empty && tx_ready;
    assign w_push  = w_accept && (!w_full || w_pop);
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    function automatic logic [7:0] f_hex(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [7:0] f_char(input logic [EW-1:0] e, input logic [3:0] i);
        logic        io;
        logic [15:0] a;
        logic [7:0]  t;
`ifdef BUS_TRACE_IORQ_EN
        io = e[EW-1];
`else
        io = 1'b0;
`endif
        a = io ? {8'h00, e[15:8]} : e[23:8];
        t = io ? (e[24] ? 8'h4F : 8'h49) : (e[24] ? 8'h57 : 8'h52);
        case (i)
            4'd0:    return t;
            4'd1:    return 8'h20;
            4'd2:    return f_hex(a[15:12]);
            4'd3:    return f_hex(a[11:8]);
            4'd4:    return f_hex(a[7:4]);
            4'd5:    return f_hex(a[3:0]);
            4'd6:    return 8'h20;
            4'd7:    return f_hex(e[7:4]);
            4'd8:    return f_hex(e[3:0]);
            4'd9:    return 8'h0D;
            default: return 8'h0A;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= w_entry;
    end

    always_ff @(posedge clk or negedge greset) begin
        if (!greset) begin
            r_mreq_sync <= 2'b11;
            r_rd_sync   <= 2'b11;
            r_wr_sync   <= 2'b11;
            r_prev      <= 1'b0;
            r_arm       <= 2'd0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_overflow  <= 1'b0;
            r_dropped   <= 8'h00;
            r_led       <= 24'd0;
        end else begin
            r_mreq_sync <= {r_mreq_sync[0], MREQ_n};
            r_rd_sync   <= {r_rd_sync[0], RD_n};
            r_wr_sync   <= {r_wr_sync[0], WR_n};
            r_prev      <= w_act;
            if (r_arm != 2'd2) r_arm <= r_arm + 2'd1;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_accept && !w_push) begin
                r_overflow <= 1'b1;
                if (r_dropped != 8'hFF) r_dropped <= r_dropped + 8'd1;
            end
            if (w_accept)           r_led <= LED_HOLD;
            else if (r_led != 24'd0) r_led <= r_led - 24'd1;
        end
    end

    always_ff @(posedge clk or negedge greset) begin
        if (!greset) begin
            r_state   <= ST_IDLE;
            r_idx     <= 4'd0;
            r_line    <= '0;
            r_tx_data <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: if (w_pop) begin
                    r_line    <= w_head;
                    r_idx     <= 4'd0;
                    r_tx_data <= f_char(w_head, 4'd0);
                    r_state   <= ST_SEND;
                end
                ST_SEND: if (tx_ready) r_state <= ST_GAP;
                ST_GAP: begin
                    if (r_idx == 4'd10) begin
                        r_tx_data <= 8'h00;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_idx     <= r_idx + 4'd1;
                        r_tx_data <= f_char(r_line, r_idx + 4'd1);
                        r_state   <= ST_SEND;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Gating with tx_ready keeps a request from ever appearing while the UART is busy
    assign tx_req   = (r_state == ST_SEND) && tx_ready;
    assign tx_data  = r_tx_data;
    assign overflow = r_overflow;
    assign dropped  = r_dropped;
    assign LED1     = (r_led != 24'd0);
endmodule

// File: tb/tb_bus_trace_uart.sv
// tb/tb_bus_trace_uart.sv - directed self-checking bench for bus_trace_uart.
module tb_bus_trace_uart;
    logic        clk = 1'b0;
    logic        greset = 1'b0;
    logic [15:0] A = 16'h0000;
    logic [7:0]  D_IN = 8'h00;
    logic        MREQ_n = 1'b1, RD_n = 1'b1, WR_n = 1'b1;
    logic        tx_ready = 1'b1;
`ifdef BUS_TRACE_IORQ_EN
    logic        IORQ_n = 1'b1;
`endif
    logic        tx_req0, tx_req1, ovf0, ovf1, led0, led1;
    logic [7:0]  tx_data0, tx_data1, drop0, drop1;

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    bus_trace_uart u_dut (
        .clk(clk), .greset(greset), .A(A), .D_IN(D_IN),
        .MREQ_n(MREQ_n), .RD_n(RD_n), .WR_n(WR_n),
`ifdef BUS_TRACE_IORQ_EN
        .IORQ_n(IORQ_n),
`endif
        .tx_req(tx_req0), .tx_data(tx_data0), .tx_ready(tx_ready),
        .overflow(ovf0), .dropped(drop0), .LED1(led0)
    );

    bus_trace_uart #(.DIR_MASK(2'b10), .LED_HOLD(24'd20)) u_dut_w (
        .clk(clk), .greset(greset), .A(A), .D_IN(D_IN),
        .MREQ_n(MREQ_n), .RD_n(RD_n), .WR_n(WR_n),
`ifdef BUS_TRACE_IORQ_EN
        .IORQ_n(IORQ_n),
`endif
        .tx_req(tx_req1), .tx_data(tx_data1), .tx_ready(tx_ready),
        .overflow(ovf1), .dropped(drop1), .LED1(led1)
    );

    always @(negedge clk) begin
        if (tx_req0) q0.push_back(tx_data0);
        if (tx_req1) q1.push_back(tx_data1);
    end

    task automatic check(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [7:0] hx(input logic [3:0] n);
        string digits;
        digits = "0123456789ABCDEF";
        return digits[n];
    endfunction

    function automatic logic [87:0] mkline(input logic [7:0] t, input logic [15:0] a, input logic [7:0] d);
        return {t, 8'h20, hx(a[15:12]), hx(a[11:8]), hx(a[7:4]), hx(a[3:0]),
                8'h20, hx(d[7:4]), hx(d[3:0]), 8'h0D, 8'h0A};
    endfunction

    task automatic take(input int which, output logic [87:0] l);
        logic [7:0] b;
        l = '0;
        for (int i = 0; i < 11; i++) begin
            b = 8'hxx;
            if (which == 0 && q0.size() > 0) b = q0.pop_front();
            if (which == 1 && q1.size() > 0) b = q1.pop_front();
            l = {l[79:0], b};
        end
    endtask

    task automatic wait_q(input int which, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((which == 0 ? q0.size() : q1.size()) >= n) return;
            @(negedge clk);
        end
    endtask

    task automatic bus(input logic [15:0] a, input logic [7:0] d, input bit wr);
        @(negedge clk);
        A = a; D_IN = d; MREQ_n = 1'b0;
        if (wr) WR_n = 1'b0; else RD_n = 1'b0;
        repeat (6) @(negedge clk);
        MREQ_n = 1'b1; RD_n = 1'b1; WR_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [87:0] l;
        bit hit;

        repeat (3) @(negedge clk);
        check("rst_tx_req",   {87'd0, tx_req0}, 88'd0);
        check("rst_tx_data",  {80'd0, tx_data0}, 88'd0);
        check("rst_overflow", {87'd0, ovf0}, 88'd0);
        check("rst_dropped",  {80'd0, drop0}, 88'd0);
        check("rst_led",      {87'd0, led0}, 88'd0);
        greset = 1'b1;
        repeat (4) @(negedge clk);

        bus(16'h2ABC, 8'h5E, 1'b1);
        wait_q(0, 11, 100);
        repeat (30) @(negedge clk);
        check("wr_count", 88'(q0.size()), 88'd11);
        take(0, l);
        check("wr_line", l, {"W 2ABC 5E", 8'h0D, 8'h0A});
        check("wr_led", {87'd0, led0}, 88'd1);

        bus(16'h4000, 8'h11, 1'b0);
        bus(16'h1FFF, 8'h22, 1'b0);
        bus(16'h3FFF, 8'hA0, 1'b0);
        wait_q(0, 11, 100);
        repeat (30) @(negedge clk);
        check("win_count", 88'(q0.size()), 88'd11);
        take(0, l);
        check("win_line", l, {"R 3FFF A0", 8'h0D, 8'h0A});

        tx_ready = 1'b0;
        for (int i = 0; i < 20; i++) bus(16'(16'h2000 + i), 8'(8'h10 + i), 1'b1);
        repeat (5) @(negedge clk);
        check("ovf_flag",    {87'd0, ovf0}, 88'd1);
        check("ovf_dropped", {80'd0, drop0}, 88'd4);
        check("ovf_stalled", 88'(q0.size()), 88'd0);
        tx_ready = 1'b1;
        wait_q(0, 176, 1000);
        repeat (30) @(negedge clk);
        check("ovf_count", 88'(q0.size()), 88'd176);
        for (int i = 0; i < 16; i++) begin
            take(0, l);
            check($sformatf("ovf_line%0d", i), l, mkline("W", 16'(16'h2000 + i), 8'(8'h10 + i)));
        end

        q1.delete();
        bus(16'h2100, 8'h42, 1'b1);
        wait_q(0, 4, 100);
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (tx_req0) hit = 1'b1;
        end
        check("abort_hit_byte5", {87'd0, hit}, 88'd1);
        greset = 1'b0;
        #1;
        check("abort_tx_req", {87'd0, tx_req0}, 88'd0);
        repeat (3) @(negedge clk);
        q0.delete();
        q1.delete();
        greset = 1'b1;
        repeat (50) @(negedge clk);
        check("abort_no_bytes", 88'(q0.size()), 88'd0);
        check("abort_overflow", {87'd0, ovf0}, 88'd0);
        check("abort_dropped",  {80'd0, drop0}, 88'd0);

        bus(16'h2001, 8'h33, 1'b0);
        bus(16'h2001, 8'h77, 1'b1);
        wait_q(0, 22, 200);
        wait_q(1, 11, 200);
        repeat (40) @(negedge clk);
        check("mask_count", 88'(q1.size()), 88'd11);
        take(1, l);
        check("mask_line", l, {"W 2001 77", 8'h0D, 8'h0A});
        take(0, l);
        check("both_rd_line", l, {"R 2001 33", 8'h0D, 8'h0A});
        take(0, l);
        check("both_wr_line", l, {"W 2001 77", 8'h0D, 8'h0A});
        check("led_expired", {87'd0, led1}, 88'd0);
        check("led_held",    {87'd0, led0}, 88'd1);

`ifdef BUS_TRACE_IORQ_EN
        q0.delete();
        @(negedge clk);
        A = 16'hFF80; D_IN = 8'h01; IORQ_n = 1'b0; WR_n = 1'b0;
        repeat (6) @(negedge clk);
        IORQ_n = 1'b1; WR_n = 1'b1;
        wait_q(0, 11, 100);
        take(0, l);
        check("io_line", l, {"O 0080 01", 8'h0D, 8'h0A});
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
